// File: rtl/pal_timing_generator.sv
// pal_timing_generator: free-running 625-line/50 Hz PAL raster timing at 864 samples per line.
// Every output is a registered decode of the counters, so all outputs move on the same edge.
`default_nettype none

module pal_timing_generator (
  input  logic       palClock,
  input  logic       resetN,
  output logic [9:0] hPos,
  output logic [9:0] vPos,
  output logic       blank,
  output logic       sync,
  output logic       burst,
  output logic       burstPhase,
  output logic       field,
  output logic       frameStart
);

  typedef enum logic [1:0] {
    HALF_NONE   = 2'd0,
    HALF_NORMAL = 2'd1,
    HALF_EQ     = 2'd2,
    HALF_BROAD  = 2'd3
  } half_e;

  logic [9:0] h_count_q, h_count_d;
  logic [9:0] line_q, line_d;
  logic       phase_q, phase_d;

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       blank_q, blank_d;
  logic       sync_q, sync_d;
  logic       burst_q, burst_d;
  logic       burst_phase_q, burst_phase_d;
  logic       field_q, field_d;
  logic       frame_start_q, frame_start_d;

  logic       h_wrap;
  half_e      first_half, second_half, cur_half;
  logic [9:0] half_off;
  logic [8:0] line_f1, line_f2;
  logic       active_line;

  always_comb begin
    h_wrap    = (h_count_q == 10'd863);
    h_count_d = h_wrap ? 10'd0 : h_count_q + 10'd1;
    line_d    = line_q;
    phase_d   = phase_q;
    if (h_wrap) begin
      line_d  = (line_q == 10'd625) ? 10'd1 : line_q + 10'd1;
      phase_d = ~phase_q;
    end
  end

  // Sync shape of each half-line across the two field-blanking intervals.
  always_comb begin
    first_half  = HALF_NORMAL;
    second_half = HALF_NONE;
    if (line_q <= 10'd2) begin
      first_half  = HALF_BROAD;
      second_half = HALF_BROAD;
    end else if (line_q == 10'd3) begin
      first_half  = HALF_BROAD;
      second_half = HALF_EQ;
    end else if (line_q <= 10'd5) begin
      first_half  = HALF_EQ;
      second_half = HALF_EQ;
    end else if (line_q <= 10'd310) begin
      first_half  = HALF_NORMAL;
      second_half = HALF_NONE;
    end else if (line_q <= 10'd312) begin
      first_half  = HALF_EQ;
      second_half = HALF_EQ;
    end else if (line_q == 10'd313) begin
      first_half  = HALF_EQ;
      second_half = HALF_BROAD;
    end else if (line_q <= 10'd315) begin
      first_half  = HALF_BROAD;
      second_half = HALF_BROAD;
    end else if (line_q <= 10'd317) begin
      first_half  = HALF_EQ;
      second_half = HALF_EQ;
    end else if (line_q == 10'd318) begin
      first_half  = HALF_EQ;
      second_half = HALF_NONE;
    end else if (line_q <= 10'd622) begin
      first_half  = HALF_NORMAL;
      second_half = HALF_NONE;
    end else if (line_q == 10'd623) begin
      first_half  = HALF_NORMAL;
      second_half = HALF_EQ;
    end else begin
      first_half  = HALF_EQ;
      second_half = HALF_EQ;
    end
  end

  always_comb begin
    hpos_d = (h_count_q >= 10'd132) ? h_count_q - 10'd132 : h_count_q + 10'd732;

    line_f1     = 9'(line_q - 10'd23);
    line_f2     = 9'(line_q - 10'd335);
    active_line = 1'b0;
    vpos_d      = 10'h3FF;
    if (line_q >= 10'd23 && line_q <= 10'd310) begin
      active_line = 1'b1;
      vpos_d      = {line_f1, 1'b0};
    end else if (line_q >= 10'd335 && line_q <= 10'd622) begin
      active_line = 1'b1;
      vpos_d      = {line_f2, 1'b1};
    end
    blank_d = !(active_line && (hpos_d < 10'd720));

    cur_half = (h_count_q >= 10'd432) ? second_half : first_half;
    half_off = (h_count_q >= 10'd432) ? h_count_q - 10'd432 : h_count_q;
    case (cur_half)
      HALF_NORMAL: sync_d = (half_off < 10'd64);
      HALF_EQ:     sync_d = (half_off < 10'd32);
      HALF_BROAD:  sync_d = (half_off < 10'd369);
      default:     sync_d = 1'b0;
    endcase

    burst_d = (h_count_q >= 10'd76) && (h_count_q <= 10'd105) &&
              (((line_q >= 10'd7) && (line_q <= 10'd310)) ||
               ((line_q >= 10'd320) && (line_q <= 10'd622)));
    burst_phase_d = phase_q;
    field_d       = (line_q >= 10'd313);
    frame_start_d = (h_count_q == 10'd0) && (line_q == 10'd1);
  end

  always_ff @(posedge palClock or negedge resetN) begin
    if (!resetN) begin
      h_count_q     <= 10'd0;
      line_q        <= 10'd1;
      phase_q       <= 1'b0;
      hpos_q        <= 10'd0;
      vpos_q        <= 10'h3FF;
      blank_q       <= 1'b1;
      sync_q        <= 1'b0;
      burst_q       <= 1'b0;
      burst_phase_q <= 1'b0;
      field_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_count_q     <= h_count_d;
      line_q        <= line_d;
      phase_q       <= phase_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      blank_q       <= blank_d;
      sync_q        <= sync_d;
      burst_q       <= burst_d;
      burst_phase_q <= burst_phase_d;
      field_q       <= field_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hPos       = hpos_q;
  assign vPos       = vpos_q;
  assign blank      = blank_q;
  assign sync       = sync_q;
  assign burst      = burst_q;
  assign burstPhase = burst_phase_q;
  assign field      = field_q;
  assign frameStart = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_pal_timing_generator.sv
// tb_pal_timing_generator: compares every output cycle against an arithmetic raster model,
// with directed line visits and randomized jumps into the raster via the counter registers.
`default_nettype none

module tb_pal_timing_generator;

  logic       palClock;
  logic       resetN;
  logic [9:0] hPos, vPos;
  logic       blank, sync, burst, burstPhase, field, frameStart;

  pal_timing_generator dut (
    .palClock  (palClock),
    .resetN    (resetN),
    .hPos      (hPos),
    .vPos      (vPos),
    .blank     (blank),
    .sync      (sync),
    .burst     (burst),
    .burstPhase(burstPhase),
    .field     (field),
    .frameStart(frameStart)
  );

  initial palClock = 1'b0;
  always #5 palClock = ~palClock;

  localparam logic [25:0] RESET_VEC = {10'd0, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  int n_tests = 0;
  int n_fail  = 0;

  // Model counters: the raster position the next edge will decode.
  int cH, cL, cP;
  logic [25:0] obs, expv;
  logic [25:0] first_seq [900];

  logic [9:0] j_h, j_l;
  logic       j_p;

  int s_sync, s_rises, s_burst, s_burst_first, s_active, s_first_vpos;
  int s_first_hpos, s_last_hpos, s_vbad, s_field, s_bphase;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] model(input int h, input int l, input int p);
    int hp, vp, f, s, t, off, w;
    bit act, bl, sy, bu, fi, fs;
    hp  = (h + 864 - 132) % 864;
    act = 0;
    vp  = 1023;
    if (l >= 23 && l <= 310) begin
      act = 1; vp = 2 * (l - 23);
    end else if (l >= 335 && l <= 622) begin
      act = 1; vp = 2 * (l - 335) + 1;
    end
    bl = !(act && hp < 720);
    // half kinds: 0 none, 1 normal, 2 equalising, 3 broad
    if (l <= 2)        begin f = 3; s = 3; end
    else if (l == 3)   begin f = 3; s = 2; end
    else if (l <= 5)   begin f = 2; s = 2; end
    else if (l <= 310) begin f = 1; s = 0; end
    else if (l <= 312) begin f = 2; s = 2; end
    else if (l == 313) begin f = 2; s = 3; end
    else if (l <= 315) begin f = 3; s = 3; end
    else if (l <= 317) begin f = 2; s = 2; end
    else if (l == 318) begin f = 2; s = 0; end
    else if (l <= 622) begin f = 1; s = 0; end
    else if (l == 623) begin f = 1; s = 2; end
    else               begin f = 2; s = 2; end
    t   = (h < 432) ? f : s;
    off = h % 432;
    w   = (t == 1) ? 64 : (t == 2) ? 32 : (t == 3) ? 369 : 0;
    sy  = off < w;
    bu  = (h >= 76) && (h <= 105) && ((l >= 7 && l <= 310) || (l >= 320 && l <= 622));
    fi  = l >= 313;
    fs  = (h == 0) && (l == 1);
    return {10'(hp), 10'(vp), bl, sy, bu, p[0], fi, fs};
  endfunction

  task automatic tick();
    @(posedge palClock);
    if (!resetN) begin
      expv = RESET_VEC;
      cH = 0; cL = 1; cP = 0;
    end else begin
      expv = model(cH, cL, cP);
      cH++;
      if (cH == 864) begin
        cH = 0;
        cL = (cL == 625) ? 1 : cL + 1;
        cP ^= 1;
      end
    end
    #1;
    obs = {hPos, vPos, blank, sync, burst, burstPhase, field, frameStart};
    check("outputs", 32'(obs), 32'(expv));
  endtask

  // Place the counters at (l, h, p); the forced edge itself is checked,
  // then the counters are handed back already advanced to the next position.
  task automatic jump(input int l, input int h, input int p);
    @(negedge palClock);
    j_h = 10'(h); j_l = 10'(l); j_p = p[0];
    force dut.h_count_q = j_h;
    force dut.line_q    = j_l;
    force dut.phase_q   = j_p;
    cH = h; cL = l; cP = p & 1;
    tick();
    @(negedge palClock);
    j_h = 10'(cH); j_l = 10'(cL); j_p = cP[0];
    force dut.h_count_q = j_h;
    force dut.line_q    = j_l;
    force dut.phase_q   = j_p;
    release dut.h_count_q;
    release dut.line_q;
    release dut.phase_q;
  endtask

  // Next edge decodes sample 0 of line l; fpar selects the frame's line-1 phase.
  task automatic goto_line(input int l, input int fpar);
    int lp;
    lp = (l == 1) ? 625 : l - 1;
    jump(lp, 863, ((lp - 1) & 1) ^ fpar);
  endtask

  task automatic run_line();
    logic prev;
    prev = sync;
    s_sync = 0; s_rises = 0; s_burst = 0; s_burst_first = -1; s_active = 0;
    s_first_vpos = -1; s_first_hpos = -1; s_last_hpos = -1; s_vbad = 0; s_field = 0; s_bphase = 0;
    for (int i = 0; i < 864; i++) begin
      tick();
      if (sync) s_sync++;
      if (sync && !prev) s_rises++;
      prev = sync;
      if (burst) begin
        if (s_burst_first < 0) s_burst_first = i;
        s_burst++;
      end
      if (!blank) begin
        if (s_active == 0) begin
          s_first_vpos = int'(vPos);
          s_first_hpos = int'(hPos);
        end
        s_active++;
        s_last_hpos = int'(hPos);
      end
      if (vPos != 10'h3FF) s_vbad++;
      if (field) s_field++;
      if (i == 0) s_bphase = int'(burstPhase);
    end
  endtask

  initial begin
    int idx;
    int vlines [4];
    int vexp   [4];
    int b624, b625;
    vlines = '{23, 310, 335, 622};
    vexp   = '{0, 574, 1, 575};
    j_h = '0; j_l = '0; j_p = 1'b0;
    cH = 0; cL = 1; cP = 0;

    // Reset held
    resetN = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("reset_state", 32'(obs), 32'(RESET_VEC));

    // Release and run just over one line
    @(negedge palClock);
    resetN = 1'b1;
    for (int i = 0; i < 900; i++) begin
      tick();
      first_seq[i] = obs;
    end
    check("edge1_hpos", 32'(first_seq[0][25:16]), 32'd732);
    check("edge1_vpos", 32'(first_seq[0][15:6]), 32'h3FF);
    check("edge1_blank", 32'(first_seq[0][5]), 32'd1);
    check("edge1_sync", 32'(first_seq[0][4]), 32'd1);
    check("edge1_bphase", 32'(first_seq[0][2]), 32'd0);
    check("edge1_framestart", 32'(first_seq[0][0]), 32'd1);
    idx = -1;
    for (int i = 0; i < 900; i++) if (idx < 0 && !first_seq[i][4]) idx = i;
    check("line1_sync_fall_idx", 32'(idx), 32'd369);
    idx = -1;
    for (int i = 370; i < 900; i++) if (idx < 0 && first_seq[i][4]) idx = i;
    check("line1_sync_rise_idx", 32'(idx), 32'd432);
    idx = -1;
    for (int i = 0; i < 900; i++) if (idx < 0 && first_seq[i][25:16] == 10'd0) idx = i;
    check("hpos0_edge", 32'(idx + 1), 32'd133);

    // Line 50: normal active line
    goto_line(50, 0);
    run_line();
    check("l50_sync_cnt", 32'(s_sync), 32'd64);
    check("l50_sync_pulses", 32'(s_rises), 32'd1);
    check("l50_burst_cnt", 32'(s_burst), 32'd30);
    check("l50_burst_first", 32'(s_burst_first), 32'd76);
    check("l50_active_cnt", 32'(s_active), 32'd720);
    check("l50_first_hpos", 32'(s_first_hpos), 32'd0);
    check("l50_last_hpos", 32'(s_last_hpos), 32'd719);

    // Vertical mapping at the field edges
    for (int k = 0; k < 4; k++) begin
      goto_line(vlines[k], 0);
      run_line();
      check("vpos_map", 32'(s_first_vpos), 32'(vexp[k]));
      check("vmap_active_cnt", 32'(s_active), 32'd720);
    end
    goto_line(311, 0);
    run_line();
    check("l311_active_cnt", 32'(s_active), 32'd0);
    check("l311_vpos_not_3ff", 32'(s_vbad), 32'd0);

    // Field interval
    goto_line(312, 0);
    run_line();
    check("l312_field_cnt", 32'(s_field), 32'd0);
    run_line();
    check("l313_field_cnt", 32'(s_field), 32'd864);
    check("l313_sync_cnt", 32'(s_sync), 32'd401);
    check("l313_sync_pulses", 32'(s_rises), 32'd2);
    goto_line(318, 0);
    run_line();
    check("l318_sync_cnt", 32'(s_sync), 32'd32);
    check("l318_sync_pulses", 32'(s_rises), 32'd1);
    check("l318_burst_cnt", 32'(s_burst), 32'd0);

    // Burst phase across the frame boundary: frame 1 has phase 0 on line 1
    goto_line(624, 0);
    run_line();
    b624 = s_bphase;
    run_line();
    b625 = s_bphase;
    check("bphase_l624", 32'(b624), 32'd1);
    check("bphase_l625", 32'(b625), 32'd0);
    tick();
    check("frame2_framestart", 32'(frameStart), 32'd1);
    check("frame2_l1_bphase", 32'(burstPhase), 32'd1);
    goto_line(625, 1);
    run_line();
    check("frame2_l625_bphase", 32'(s_bphase), 32'd1);
    tick();
    check("frame3_l1_bphase", 32'(burstPhase), 32'd0);

    // Reset in mid-line, then the restart must replay the first scenario
    jump(200, 400, 1);
    for (int i = 0; i < 10; i++) tick();
    @(negedge palClock);
    resetN = 1'b0;
    #1;
    check("async_reset_outputs", 32'({hPos, vPos, blank, sync, burst, burstPhase, field, frameStart}),
          32'(RESET_VEC));
    for (int i = 0; i < 3; i++) tick();
    check("mid_reset_hold", 32'(obs), 32'(RESET_VEC));
    @(negedge palClock);
    resetN = 1'b1;
    for (int i = 0; i < 900; i++) begin
      tick();
      check("restart_replay", 32'(obs), 32'(first_seq[i]));
    end

    // Randomized visits, occasionally interrupted by a short reset
    for (int it = 0; it < 25; it++) begin
      int l, h, p, len;
      l   = int'($urandom_range(1, 625));
      h   = int'($urandom_range(0, 863));
      p   = int'($urandom_range(0, 1));
      len = int'($urandom_range(200, 1500));
      jump(l, h, p);
      for (int i = 0; i < len; i++) begin
        if (i == len / 2 && $urandom_range(0, 3) == 0) begin
          @(negedge palClock);
          resetN = 1'b0;
          for (int r = 0; r < int'($urandom_range(1, 4)); r++) tick();
          @(negedge palClock);
          resetN = 1'b1;
        end
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
